// File: rtl/sampler_pkg.sv
// Shared encodings for the digital sample responder: register offsets,
// command codes, FSM states and reserved collector channel ids.
package sampler_pkg;

    localparam logic [7:0]  REG_DIVISOR = 8'd1;
    localparam logic [7:0]  REG_COMMAND = 8'd5;

    localparam logic [31:0] CMD_START = 32'd1;
    localparam logic [31:0] CMD_STOP  = 32'd2;
    localparam logic [31:0] CMD_RESET = 32'd5;

    localparam logic [7:0]  CHAN_RESERVED_LO = 8'd0;
    localparam logic [7:0]  CHAN_RESERVED_HI = 8'd255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/sample_fetch_responder.sv
// Collector fetch responder: matches the channel id, snapshots the sample
// word and drives it onto the OR-combined bus for a two-cycle window.
module sample_fetch_responder #(
    parameter int POSITION = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        output_sample,
    input  logic [7:0]  channel_select,
    input  logic [31:0] word,
    output logic [31:0] sample_data
);

    logic        request;
    logic [31:0] snapshot;
    logic [1:0]  window;

    assign request = output_sample && (channel_select == 8'(POSITION));

    // A fresh request always restarts the window with a new snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot <= '0;
            window   <= '0;
        end else if (request) begin
            snapshot <= word;
            window   <= 2'd2;
        end else if (window != 2'd0) begin
            window   <= window - 2'd1;
        end
    end

    assign sample_data = (window != 2'd0) ? snapshot : '0;

endmodule

// File: rtl/digital_sample_responder.sv
// Per-channel digital pin sampler with command-bus control and collector fetch.
// Define SAMPLE_TIMESTAMP_EN to stamp transitions with a 16-bit tick index.
module digital_sample_responder #(
    parameter int POSITION    = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int COUNT_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [31:0] cmd_data_in,
    input  logic        cs,
    input  logic        wr,
    input  logic        output_sample,
    input  logic [7:0]  channel_select,
    input  logic        global_clock_running,
    input  logic        pin_in,
    output logic [31:0] sample_data,
    output logic        running
);

    import sampler_pkg::*;

    logic                   enable;
    logic                   wr_div;
    logic                   wr_cmd;
    logic                   cmd_start;
    logic                   cmd_stop;
    logic                   cmd_reset;
    logic [1:0]             sync_q;
    logic                   pin_sync;
    state_t                 state;
    state_t                 state_next;
    logic [DIV_WIDTH-1:0]   divisor;
    logic [DIV_WIDTH-1:0]   presc;
    logic                   tick;
    logic                   level;
    logic [COUNT_WIDTH-1:0] count;
    logic [31:0]            word;

    assign enable    = cs && wr && (addr[15:8] == 8'(POSITION));
    assign wr_div    = enable && (addr[7:0] == REG_DIVISOR);
    assign wr_cmd    = enable && (addr[7:0] == REG_COMMAND);
    assign cmd_start = wr_cmd && (cmd_data_in == CMD_START);
    assign cmd_stop  = wr_cmd && (cmd_data_in == CMD_STOP);
    assign cmd_reset = wr_cmd && (cmd_data_in == CMD_RESET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], pin_in};
    end

    assign pin_sync = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cmd_reset) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (cmd_start) state_next = ARMED;
                ARMED:   if (cmd_stop) state_next = IDLE;
                         else if (global_clock_running) state_next = RUN;
                RUN:     if (cmd_stop) state_next = IDLE;
                         else if (!global_clock_running) state_next = ARMED;
                default: state_next = IDLE;
            endcase
        end
    end

    assign running = (state == RUN);
    assign tick    = running && (presc == divisor);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor <= '0;
            presc   <= '0;
            level   <= 1'b0;
            count   <= '0;
        end else if (cmd_reset) begin
            divisor <= '0;
            presc   <= '0;
            level   <= 1'b0;
            count   <= '0;
        end else begin
            if (wr_div) divisor <= cmd_data_in[DIV_WIDTH-1:0];
            if (!running || wr_div || tick) presc <= '0;
            else                            presc <= presc + 1'b1;
            if (tick) begin
                level <= pin_sync;
                if (pin_sync != level) count <= count + 1'b1;
            end
        end
    end

`ifdef SAMPLE_TIMESTAMP_EN
    logic [15:0] tick_cnt;
    logic [15:0] stamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            stamp    <= '0;
        end else if (cmd_reset) begin
            tick_cnt <= '0;
            stamp    <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 16'd1;
            if (pin_sync != level) stamp <= tick_cnt;
        end
    end
`endif

    // Word only changes on transitions, keeping collector dedup effective.
    always_comb begin
        word                = '0;
        word[0]             = level;
        word[COUNT_WIDTH:1] = count;
`ifdef SAMPLE_TIMESTAMP_EN
        word[31:16]         = stamp;
`endif
    end

    sample_fetch_responder #(
        .POSITION(POSITION)
    ) u_fetch (
        .clk           (clk),
        .rst           (rst),
        .output_sample (output_sample),
        .channel_select(channel_select),
        .word          (word),
        .sample_data   (sample_data)
    );

endmodule

// File: tb/tb_digital_sample_responder.sv
// Bench for digital_sample_responder: directed steps plus random traffic
// checked every cycle against a behavioural model of the sampling rules.
module tb_digital_sample_responder;

    localparam int POSITION    = 16;
    localparam int DIV_WIDTH   = 16;
    localparam int COUNT_WIDTH = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [31:0] cmd_data_in;
    logic        cs;
    logic        wr;
    logic        output_sample;
    logic [7:0]  channel_select;
    logic        global_clock_running;
    logic        pin_in;
    logic [31:0] sample_data;
    logic        running;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    digital_sample_responder #(
        .POSITION   (POSITION),
        .DIV_WIDTH  (DIV_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .addr                (addr),
        .cmd_data_in         (cmd_data_in),
        .cs                  (cs),
        .wr                  (wr),
        .output_sample       (output_sample),
        .channel_select      (channel_select),
        .global_clock_running(global_clock_running),
        .pin_in              (pin_in),
        .sample_data         (sample_data),
        .running             (running)
    );

    // Reference model: mode 0 idle, 1 armed, 2 run
    int          m_st;
    int          m_div;
    int          m_phase;
    int          m_count;
    int          m_win;
    int          m_ticks;
    int          m_stamp;
    bit          m_level;
    bit          m_h1;
    bit          m_h2;
    logic [31:0] m_snap;

    function automatic logic [31:0] mword();
        logic [31:0] w;
        w    = 32'(m_count) << 1;
        w[0] = m_level;
`ifdef SAMPLE_TIMESTAMP_EN
        w[31:16] = m_stamp[15:0];
`endif
        return w;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_div = 0; m_phase = 0; m_count = 0; m_win = 0;
        m_ticks = 0; m_stamp = 0; m_level = 0; m_h1 = 0; m_h2 = 0;
        m_snap = '0;
    endfunction

    function automatic void model_edge();
        bit          en, wdiv, wcmd, c_start, c_stop, c_reset, req, tick;
        logic [31:0] wpre;
        en      = cs && wr && (addr[15:8] == 8'(POSITION));
        wdiv    = en && (addr[7:0] == 8'd1);
        wcmd    = en && (addr[7:0] == 8'd5);
        c_start = wcmd && (cmd_data_in == 32'd1);
        c_stop  = wcmd && (cmd_data_in == 32'd2);
        c_reset = wcmd && (cmd_data_in == 32'd5);
        wpre    = mword();
        req     = output_sample && (channel_select == 8'(POSITION));
        // one tick every (divisor+1) run cycles
        tick    = (m_st == 2) && (m_phase == m_div);
        if (req) begin
            m_snap = wpre;
            m_win  = 2;
        end else if (m_win > 0) begin
            m_win--;
        end
        if (c_reset) begin
            m_level = 0; m_count = 0; m_div = 0; m_phase = 0;
            m_st = 0; m_ticks = 0; m_stamp = 0;
        end else begin
            if (tick) begin
                if (m_h2 != m_level) begin
                    m_count = (m_count + 1) % (1 << COUNT_WIDTH);
                    m_stamp = m_ticks;
                end
                m_level = m_h2;
                m_ticks = (m_ticks + 1) % 65536;
            end
            if (m_st == 2 && !wdiv && !tick) m_phase++;
            else m_phase = 0;
            if (wdiv) m_div = int'(cmd_data_in[DIV_WIDTH-1:0]);
            case (m_st)
                0: if (c_start) m_st = 1;
                1: if (c_stop) m_st = 0;
                   else if (global_clock_running) m_st = 2;
                2: if (c_stop) m_st = 0;
                   else if (!global_clock_running) m_st = 1;
                default: m_st = 0;
            endcase
        end
        m_h2 = m_h1;
        m_h1 = pin_in;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("sample_data", sample_data, (m_win > 0) ? m_snap : 32'd0);
        check("running", {31'd0, running}, {31'd0, (m_st == 2)});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_reg(input logic [7:0] r, input logic [31:0] d);
        cs = 1; wr = 1; addr = {8'(POSITION), r}; cmd_data_in = d;
        step();
        cs = 0; wr = 0;
    endtask

    task automatic fetch_expect(input string tag, input logic [31:0] mask,
                                input logic [31:0] exp);
        output_sample = 1; channel_select = 8'(POSITION);
        step();
        output_sample = 0;
        check(tag, sample_data & mask, exp);
        step();
    endtask

    logic [31:0] frozen;

    initial begin
        model_reset();
        rst = 1; addr = '0; cmd_data_in = '0; cs = 0; wr = 0;
        output_sample = 0; channel_select = '0;
        global_clock_running = 0; pin_in = 0;
        steps(2);
        check("reset_sample_data", sample_data, 32'd0);
        check("reset_running", {31'd0, running}, 32'd0);
        rst = 0;
        step();

        // fetch right after reset: zero word for two cycles, then zero
        fetch_expect("reset_word", 32'hFFFF_FFFF, 32'd0);
        step();
        check("window_end", sample_data, 32'd0);

        // divisor 3, start, pin 0 -> 1
        write_reg(8'd1, 32'd3);
        write_reg(8'd5, 32'd1);
        global_clock_running = 1;
        steps(6);
        pin_in = 1;
        steps(12);
        fetch_expect("first_transition", 32'h0000_FFFF, 32'h0000_0003);

        // continuous fetch while the pin toggles: tick spacing checked per cycle
        output_sample = 1; channel_select = 8'(POSITION);
        for (int i = 0; i < 24; i++) begin
            if (i == 3 || i == 13) pin_in = ~pin_in;
            step();
        end
        output_sample = 0;
        steps(4);

        // other channel must not answer
        output_sample = 1; channel_select = 8'(POSITION + 1);
        step();
        output_sample = 0;
        check("wrong_chan_1", sample_data, 32'd0);
        step();
        check("wrong_chan_2", sample_data, 32'd0);

        // back-to-back requests stretch the window to three cycles
        output_sample = 1; channel_select = 8'(POSITION);
        steps(2);
        output_sample = 0;
        step();
        check("b2b_tail", sample_data, mword());
        step();
        check("b2b_end", sample_data, 32'd0);

        // stop freezes the word
        frozen = mword();
        write_reg(8'd5, 32'd2);
        for (int i = 0; i < 20; i++) begin
            pin_in = 1'($urandom);
            step();
        end
        check("stopped_running", {31'd0, running}, 32'd0);
        fetch_expect("frozen", 32'hFFFF_FFFF, frozen);

        // clock gating: RUN <-> ARMED
        write_reg(8'd5, 32'd1);
        steps(3);
        check("run_again", {31'd0, running}, 32'd1);
        global_clock_running = 0;
        steps(2);
        check("armed_gated", {31'd0, running}, 32'd0);
        global_clock_running = 1;
        steps(3);

        // command reset clears the word and returns to IDLE
        write_reg(8'd5, 32'd5);
        step();
        check("cmd_reset_idle", {31'd0, running}, 32'd0);
        fetch_expect("cmd_reset_word", 32'hFFFF_FFFF, 32'd0);

        // counter wrap with divisor 0: each toggle is one transition
        pin_in = 0;
        write_reg(8'd5, 32'd1);
        steps(4);
        for (int i = 0; i < 4095; i++) begin
            pin_in = ~pin_in;
            step();
        end
        steps(4);
        fetch_expect("count_4095", 32'h0000_FFFF, 32'h0000_1FFF);
        pin_in = ~pin_in;
        steps(4);
        fetch_expect("count_wrap", 32'h0000_FFFF, 32'h0000_0000);
        pin_in = ~pin_in;
        steps(4);
        fetch_expect("count_after_wrap", 32'h0000_FFFF, 32'h0000_0003);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2, 0) == 0) pin_in = ~pin_in;
            if ($urandom_range(19, 0) == 0)
                global_clock_running = ~global_clock_running;
            output_sample = ($urandom_range(3, 0) == 0);
            case ($urandom_range(2, 0))
                0:       channel_select = 8'(POSITION);
                1:       channel_select = 8'(POSITION + 1);
                default: channel_select = 8'($urandom);
            endcase
            if ($urandom_range(15, 0) == 0) begin
                cs = 1; wr = 1;
                case ($urandom_range(3, 0))
                    0: begin
                        addr = {8'(POSITION), 8'd1};
                        cmd_data_in = 32'($urandom_range(5, 0));
                    end
                    1: begin
                        addr = {8'(POSITION), 8'd5};
                        cmd_data_in = 32'd1;
                    end
                    2: begin
                        addr = {8'(POSITION), 8'd5};
                        cmd_data_in = 32'd2;
                    end
                    default: begin
                        addr = {8'(POSITION + 1), 8'd5};
                        cmd_data_in = 32'd5;
                    end
                endcase
            end else begin
                cs = 0; wr = 0;
            end
            step();
        end
        cs = 0; wr = 0; output_sample = 0;
        steps(3);

        // asynchronous reset in the middle of a response window
        pin_in = 1;
        write_reg(8'd5, 32'd1);
        global_clock_running = 1;
        steps(8);
        output_sample = 1; channel_select = 8'(POSITION);
        step();
        output_sample = 0;
        #2 rst = 1;
        #1 check("async_rst_data", sample_data, 32'd0);
        check("async_rst_running", {31'd0, running}, 32'd0);
        step();
        rst = 0;
        steps(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
